instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the PC, drives the word address into the combinational instruction ROM, samples the returned word and buffers it in a small FIFO for the decode stage.
- Decode consumes instructions through a valid/ready handshake.
- The execute stage redirects fetch on branch/jump, which flushes the buffer.
- Sits between the instruction ROM and decode in the MIPS datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
- FAULT_WORD, 32'hFFFF_FFFF, ROM default/unmapped word; treated as a fetch fault.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  output  32  instruction ROM address = PC (combinational from PC register).
- Word  input  32  instruction ROM data, valid in the same cycle as Address.
- instr_valid  output  1  FIFO head is valid.
- instr_ready  input  1  decode accepts the head this cycle.
- instr_word  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  new PC.
- fetch_fault  output  1  fetch halted on fault.

Behaviour:
- Interface decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset: PC=RESET_PC, FIFO empty (count=0, pointers 0), state=FETCH. Outputs: instr_valid=0, instr_word=0, instr_pc=0, fetch_fault=0, Address=RESET_PC. Reset overrides every other input in the same cycle.
- States:
  - FETCH: normal fetching.
  - HALT: a fault occurred; no fetch. fetch_fault=1 only in HALT.
- Push in FETCH when count<DEPTH and no redirect:
  - Word!=FAULT_WORD: write {Word, PC}, PC<=PC+4.
  - Word==FAULT_WORD: no write, PC holds, state->HALT.
  - Count==DEPTH: no push, PC holds. There is no pass-through when full, even if a pop occurs in the same cycle.
- Pop: when instr_valid&&instr_ready, advance the read pointer.
- Simultaneous push and pop: count unchanged.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect has top priority after reset:
  - Flush FIFO (count=0).
  - Any push or pop in that cycle is discarded; decode treats a handshake in a redirect cycle as squashed.
  - PC<=redirect_pc, state->FETCH.
  - If redirect_pc[1:0]!=0: PC still loads, but state->HALT (misaligned fault).
- Latency:
  - Reset deasserted at edge E0: first instr_valid after E1 (word at RESET_PC).
  - Redirect sampled at edge N: Address=redirect_pc from N; instr_valid with instr_pc=redirect_pc after edge N+1.
- Throughput: 1 instruction/cycle while decode is ready.
- HALT: FIFO continues draining to decode; Address holds the faulting PC. Exit from HALT is only via redirect (aligned) or reset.
- instr_word and instr_pc are don't-care when instr_valid=0. The bench checks them only while valid.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_stall (32 bits).
  - perf_fetched increments on each successful push.
  - perf_stall increments each cycle in FETCH where count==DEPTH and no redirect.
  - Both reset to 0, wrap modulo 2^32, and do not clear on redirect.
- Undefined: no counters, no extra ports; all other behaviour identical.

Test Plan:
- Reset release, instr_ready=1 held, ROM returns distinct words at 0,4,8 -> instr_valid after the first edge; instr_pc sequence 0,4,8 with one instruction per cycle; fetch_fault=0.
- instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, Address holds at 16, count stays 4. Raise ready -> heads pc 0,4,8,12 then 16 with no gap.
- Redirect to 32'h0000_0040 while FIFO holds 3 entries and ready=1 -> entries and that cycle's handshake dropped; next valid head has instr_pc=0x40 two edges after redirect.
- ROM returns 32'hFFFF_FFFF at PC 0x0C -> pcs 0,4,8 delivered, then fetch_fault=1 and Address stays 0x0C. Aligned redirect to 0 -> fault clears and fetch resumes from 0.
- Redirect to 32'h0000_0042 -> fetch_fault=1 next cycle, no pushes. Redirect to 32'hFFFF_FFFC -> pcs FFFF_FFFC then 0 (wrap).
- With IFETCH_PERF_EN: 4-entry fill followed by 6 stalled cycles -> perf_fetched=4, perf_stall=6. Reset mid-run -> both counters 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch initiator. Owns the PC, presents it as the
//                combinational ROM address, captures the returned word into a
//                small prefetch FIFO and hands instructions to decode through
//                a valid/ready handshake. A redirect from execute flushes the
//                FIFO and restarts fetch at the new PC. Fetching an unmapped
//                word (FAULT_WORD) or redirecting to a misaligned PC halts
//                fetch until the next aligned redirect or reset.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                Address / Word        - ROM address (= PC) and returned data
//                instr_valid/ready     - decode handshake for the FIFO head
//                instr_word/instr_pc   - head instruction and its PC
//                redirect_valid/_pc    - branch/jump redirect from execute
//                fetch_fault           - high while fetch is halted on a fault
//                perf_fetched/_stall   - only with IFETCH_PERF_EN defined
//  Options     : IFETCH_PERF_EN - adds fetched/stall performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] FAULT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Address,
    input  logic [31:0] Word,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        fetch_fault
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        c_ST_FETCH = 1'b0,
        c_ST_HALT  = 1'b1
    } state_t;

    state_t               r_state_q,  w_state_d;
    logic [31:0]          r_pc_q,     w_pc_d;
    logic [c_PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]   r_count_q,  w_count_d;

    logic [31:0]          r_mem_word_q [DEPTH];
    logic [31:0]          r_mem_pc_q   [DEPTH];

    logic                 w_full;
    logic                 w_can_fetch;
    logic                 w_fault;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_stall;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Address     = r_pc_q;
    assign instr_valid = (r_count_q != '0);
    assign fetch_fault = (r_state_q == c_ST_HALT);
    // Gated so the head reads as zero after reset without clearing storage.
    assign instr_word  = instr_valid ? r_mem_word_q[r_rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? r_mem_pc_q[r_rd_ptr_q]   : 32'h0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_full      = (r_count_q == c_DEPTH);
        // No pass-through when full: a same-cycle pop does not free a slot.
        w_can_fetch = (r_state_q == c_ST_FETCH) && !w_full && !redirect_valid;
        w_fault     = w_can_fetch && (Word == FAULT_WORD);
        w_push      = w_can_fetch && (Word != FAULT_WORD);
        // A handshake in a redirect cycle is squashed.
        w_pop       = instr_valid && instr_ready && !redirect_valid;
        w_stall     = (r_state_q == c_ST_FETCH) && w_full && !redirect_valid;

        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_count_d   = r_count_q;

        if (redirect_valid) begin
            w_pc_d     = redirect_pc;
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
            w_state_d  = (redirect_pc[1:0] != 2'b00) ? c_ST_HALT : c_ST_FETCH;
        end else begin
            if (w_push) begin
                w_pc_d     = r_pc_q + 32'd4;
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
            end
            if (w_fault) begin
                w_state_d = c_ST_HALT;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
                2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= c_ST_FETCH;
            r_pc_q     <= RESET_PC;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // FIFO storage: contents are only observed through the count, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_word_q[r_wr_ptr_q] <= Word;
            r_mem_pc_q[r_wr_ptr_q]   <= r_pc_q;
        end
    end

`ifdef IFETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (survive redirects, wrap naturally)
    // ------------------------------------------------------------------------
    logic [31:0] r_perf_fetched_q, w_perf_fetched_d;
    logic [31:0] r_perf_stall_q,   w_perf_stall_d;

    always_comb begin
        w_perf_fetched_d = r_perf_fetched_q;
        w_perf_stall_d   = r_perf_stall_q;
        if (w_push) begin
            w_perf_fetched_d = r_perf_fetched_q + 32'd1;
        end
        if (w_stall) begin
            w_perf_stall_d = r_perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched_q <= 32'h0;
            r_perf_stall_q   <= 32'h0;
        end else begin
            r_perf_fetched_q <= w_perf_fetched_d;
            r_perf_stall_q   <= w_perf_stall_d;
        end
    end

    assign perf_fetched = r_perf_fetched_q;
    assign perf_stall   = r_perf_stall_q;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Stimulus pushes the
//                expected {word, pc} of every instruction decode will accept
//                into a queue; a negedge monitor pops and compares on each
//                accepted handshake. Directed checks cover reset, fill/stall,
//                redirect flush, fetch fault, misaligned redirect and PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Word;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    // ROM model controls
    logic        fault_en;
    logic [31:0] fault_pc;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    // Combinational ROM: distinct word per address, FAULT_WORD at fault_pc.
    assign Word = (fault_en && (Address == fault_pc)) ? 32'hFFFF_FFFF
                                                      : (Address ^ 32'h5A00_0000);

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .Address        (Address),
        .Word           (Word),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word     (instr_word),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({rom_word(pc), pc});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted handshake must match the queue head.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && instr_ready && (instr_valid === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got pc %h word %h, expected none",
                         instr_pc, instr_word);
            end else begin
                mon_exp = exp_q.pop_front();
                check("head_word", instr_word, mon_exp[63:32]);
                check("head_pc",   instr_pc,   mon_exp[31:0]);
            end
        end
    end

    // Redirect with ready high, then accept the first two refetched words.
    task automatic redirect_take2(input string tag, input logic [31:0] tgt,
                                  input logic [31:0] nxt);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        check({tag, "_addr"},    Address,            tgt);
        check({tag, "_fault"},   32'(fetch_fault),   32'd0);
        check({tag, "_flushed"}, 32'(instr_valid),   32'd0);
        expect_fetch(tgt);
        expect_fetch(nxt);
        redirect_valid = 1'b0;
        step();
        check({tag, "_first_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_first_pc"},    instr_pc,         tgt);
        step();
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fault_en       = 1'b0;
        fault_pc       = 32'h0;
        step();
        step();

        // Reset state
        check("rst_addr",  Address,            32'h0);
        check("rst_valid", 32'(instr_valid),   32'd0);
        check("rst_word",  instr_word,         32'h0);
        check("rst_pc",    instr_pc,           32'h0);
        check("rst_fault", 32'(fetch_fault),   32'd0);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall",   perf_stall,   32'd0);
`endif

        // A: reset release with ready held, one instruction per cycle
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        reset       = 1'b0;
        instr_ready = 1'b1;
        step();
        check("a_first_valid", 32'(instr_valid), 32'd1);
        check("a_first_pc",    instr_pc,         32'h0);
        check("a_fault",       32'(fetch_fault), 32'd0);
        step();
        step();
        step();
        instr_ready = 1'b0;
        check("a_drained", 32'(exp_q.size()), 32'd0);

        // B: fill with decode stalled, then drain without gaps
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) expect_fetch(32'(i * 4));
        repeat (10) step();
        check("b_addr_hold",  Address,            32'h10);
        check("b_valid",      32'(instr_valid),   32'd1);
        check("b_head_pc",    instr_pc,           32'h0);
        check("b_fault",      32'(fetch_fault),   32'd0);
`ifdef IFETCH_PERF_EN
        check("b_perf_fetched", perf_fetched, 32'd4);
        check("b_perf_stall",   perf_stall,   32'd6);
`endif
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("b_drain_valid", 32'(instr_valid), 32'd1);
            check("b_drain_pc",    instr_pc,         32'(i * 4));
            step();
        end
        instr_ready = 1'b0;
        check("b_drained", 32'(exp_q.size()), 32'd0);

        // C: redirect while three entries are buffered
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef IFETCH_PERF_EN
        check("c_perf_fetched_rst", perf_fetched, 32'd0);
        check("c_perf_stall_rst",   perf_stall,   32'd0);
`endif
        step();
        step();
        step();
        check("c_pre_addr", Address, 32'hC);
        redirect_take2("c_redir", 32'h40, 32'h44);

        // D: fetch fault at 0x0C, then aligned redirect to 0
        reset = 1'b1;
        step();
        reset       = 1'b0;
        fault_en    = 1'b1;
        fault_pc    = 32'hC;
        instr_ready = 1'b1;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        step();
        check("d_fault_early", 32'(fetch_fault), 32'd0);
        repeat (3) step();
        check("d_fault",      32'(fetch_fault), 32'd1);
        check("d_addr_hold",  Address,          32'hC);
        step();
        step();
        check("d_fault_held", 32'(fetch_fault), 32'd1);
        check("d_addr_held",  Address,          32'hC);
        check("d_no_valid",   32'(instr_valid), 32'd0);
        fault_en = 1'b0;
        redirect_take2("d_resume", 32'h0, 32'h4);

        // E: misaligned redirect halts, then redirect near the top wraps
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("e_mis_fault", 32'(fetch_fault), 32'd1);
        check("e_mis_addr",  Address,          32'h42);
        check("e_mis_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        check("e_mis_nopush", 32'(instr_valid), 32'd0);
        check("e_mis_hold",   Address,          32'h42);
        redirect_take2("e_wrap", 32'hFFFF_FFFC, 32'h0);

        step();
        step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
